// File: rtl/wb_sdrc_arbiter.sv
// Round-robin arbiter for the SDRAM controller Wishbone port: whole cycles, one grant-cycle latency, combinational ack path.
// Masters wait on ack (no preemption, grants held off until sdr_init_done); WB_ARB_TIMEOUT_EN adds a no-ack abort with mN_wb_err_o.
module wb_sdrc_arbiter #(
   parameter int dw      = 32,
   parameter int APP_AW  = 26,
   parameter int TIMEOUT = 256
) (
   input  logic                sys_clk,
   input  logic                wb_rst_i,
   input  logic                sdr_init_done,
   input  logic                m0_wb_cyc_i,
   input  logic                m0_wb_stb_i,
   input  logic                m0_wb_we_i,
   input  logic [APP_AW-1:0]   m0_wb_addr_i,
   input  logic [dw-1:0]       m0_wb_dat_i,
   input  logic [dw/8-1:0]     m0_wb_sel_i,
   input  logic [2:0]          m0_wb_cti_i,
   output logic                m0_wb_ack_o,
   output logic [dw-1:0]       m0_wb_dat_o,
   output logic                m0_wb_err_o,
   input  logic                m1_wb_cyc_i,
   input  logic                m1_wb_stb_i,
   input  logic                m1_wb_we_i,
   input  logic [APP_AW-1:0]   m1_wb_addr_i,
   input  logic [dw-1:0]       m1_wb_dat_i,
   input  logic [dw/8-1:0]     m1_wb_sel_i,
   input  logic [2:0]          m1_wb_cti_i,
   output logic                m1_wb_ack_o,
   output logic [dw-1:0]       m1_wb_dat_o,
   output logic                m1_wb_err_o,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [APP_AW-1:0]   wb_addr_o,
   output logic [dw-1:0]       wb_dat_o,
   output logic [dw/8-1:0]     wb_sel_o,
   output logic [2:0]          wb_cti_o,
   input  logic                wb_ack_i,
   input  logic [dw-1:0]       wb_dat_i,
   output logic [1:0]          arb_grant
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
`ifdef WB_ARB_TIMEOUT_EN
      GNT1 = 2'd2,
      ABORT = 2'd3
`else
      GNT1 = 2'd2
`endif
   } state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          owner_stb;
   logic          timeout;

   // Stall detection uses raw master strobes to keep the path independent of the output mux.
   always_comb begin
      owner_stb = 1'b0;
      if (state_q == GNT0) owner_stb = m0_wb_stb_i;
      if (state_q == GNT1) owner_stb = m1_wb_stb_i;
      timeout = owner_stb && !wb_ack_i && (cnt_q == CW'(TIMEOUT - 1));
   end

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q != GNT0 && state_q != GNT1) || state_d != state_q || wb_ack_i)
         cnt_d = '0;
      else if (owner_stb)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge sys_clk or posedge wb_rst_i) begin
      if (wb_rst_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`endif

   always_ff @(posedge sys_clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (sdr_init_done) begin
               if (m0_wb_cyc_i && (!m1_wb_cyc_i || last_q)) state_d = GNT0;
               else if (m1_wb_cyc_i)                       state_d = GNT1;
            end
         end
         GNT0: begin
`ifdef WB_ARB_TIMEOUT_EN
            if (timeout) state_d = ABORT;
            else
`endif
            if (!m0_wb_cyc_i) state_d = (m1_wb_cyc_i && sdr_init_done) ? GNT1 : IDLE;
         end
         GNT1: begin
`ifdef WB_ARB_TIMEOUT_EN
            if (timeout) state_d = ABORT;
            else
`endif
            if (!m1_wb_cyc_i) state_d = (m0_wb_cyc_i && sdr_init_done) ? GNT0 : IDLE;
         end
`ifdef WB_ARB_TIMEOUT_EN
         // last_q still names the aborted owner; wait for it to close its cycle.
         ABORT: begin
            if (!(last_q ? m1_wb_cyc_i : m0_wb_cyc_i)) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
      if (state_d == GNT0 && state_q != GNT0) last_d = 1'b0;
      if (state_d == GNT1 && state_q != GNT1) last_d = 1'b1;
   end

   always_comb begin
      wb_cyc_o    = 1'b0;
      wb_stb_o    = 1'b0;
      wb_we_o     = 1'b0;
      wb_addr_o   = '0;
      wb_dat_o    = '0;
      wb_sel_o    = '0;
      wb_cti_o    = 3'b000;
      m0_wb_ack_o = 1'b0;
      m0_wb_dat_o = '0;
      m0_wb_err_o = 1'b0;
      m1_wb_ack_o = 1'b0;
      m1_wb_dat_o = '0;
      m1_wb_err_o = 1'b0;
      arb_grant   = 2'b00;
      case (state_q)
         GNT0: begin
            wb_cyc_o    = m0_wb_cyc_i;
            wb_stb_o    = m0_wb_stb_i;
            wb_we_o     = m0_wb_we_i;
            wb_addr_o   = m0_wb_addr_i;
            wb_dat_o    = m0_wb_dat_i;
            wb_sel_o    = m0_wb_sel_i;
            wb_cti_o    = m0_wb_cti_i;
            m0_wb_ack_o = wb_ack_i;
            m0_wb_dat_o = wb_dat_i;
`ifdef WB_ARB_TIMEOUT_EN
            m0_wb_err_o = timeout;
`endif
            arb_grant   = 2'b01;
         end
         GNT1: begin
            wb_cyc_o    = m1_wb_cyc_i;
            wb_stb_o    = m1_wb_stb_i;
            wb_we_o     = m1_wb_we_i;
            wb_addr_o   = m1_wb_addr_i;
            wb_dat_o    = m1_wb_dat_i;
            wb_sel_o    = m1_wb_sel_i;
            wb_cti_o    = m1_wb_cti_i;
            m1_wb_ack_o = wb_ack_i;
            m1_wb_dat_o = wb_dat_i;
`ifdef WB_ARB_TIMEOUT_EN
            m1_wb_err_o = timeout;
`endif
            arb_grant   = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_sdrc_arbiter.sv
// Directed bench for wb_sdrc_arbiter; timeout steps run only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_sdrc_arbiter;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 256;
`endif

   logic        clk = 1'b0;
   logic        rst, init;
   logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [25:0] m0_addr, m1_addr, s_addr;
   logic [31:0] m0_dat, m1_dat, m0_rdat, m1_rdat, s_wdat, s_rdat;
   logic [3:0]  m0_sel, m1_sel, s_sel;
   logic [2:0]  m0_cti, m1_cti, s_cti;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_cyc, s_stb, s_we, s_ack;
   logic [1:0]  grant;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] words [4];

   always #5 clk = ~clk;

   wb_sdrc_arbiter #(.dw(32), .APP_AW(26), .TIMEOUT(TO)) dut (
      .sys_clk(clk), .wb_rst_i(rst), .sdr_init_done(init),
      .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
      .m0_wb_addr_i(m0_addr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
      .m0_wb_cti_i(m0_cti), .m0_wb_ack_o(m0_ack), .m0_wb_dat_o(m0_rdat),
      .m0_wb_err_o(m0_err),
      .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
      .m1_wb_addr_i(m1_addr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
      .m1_wb_cti_i(m1_cti), .m1_wb_ack_o(m1_ack), .m1_wb_dat_o(m1_rdat),
      .m1_wb_err_o(m1_err),
      .wb_cyc_o(s_cyc), .wb_stb_o(s_stb), .wb_we_o(s_we), .wb_addr_o(s_addr),
      .wb_dat_o(s_wdat), .wb_sel_o(s_sel), .wb_cti_o(s_cti),
      .wb_ack_i(s_ack), .wb_dat_i(s_rdat), .arb_grant(grant)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
      words[2] = 32'h3333_0003; words[3] = 32'h4444_0004;
      rst = 1'b1; init = 1'b0; s_ack = 1'b0; s_rdat = '0;
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = '0; m0_dat = '0; m0_sel = '0; m0_cti = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = '0; m1_dat = '0; m1_sel = '0; m1_cti = '0;
      #3;
      chk("rst_cyc", s_cyc, 0);
      chk("rst_grant", grant, 0);
      chk("rst_addr", s_addr, 0);
      chk("rst_ack0", m0_ack, 0);
      chk("rst_err0", m0_err, 0);
      chk("rst_dat1", m1_rdat, 0);
      tick();
      rst = 1'b0;

      // Requests are held off until init completes.
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_addr = 26'h0000010;
      m0_dat = 32'hDEADBEEF; m0_sel = 4'hF; m0_cti = 3'b000;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("noinit_cyc", s_cyc, 0);
      end
      init = 1'b1;
      tick();
      chk("w_cyc", s_cyc, 1);
      chk("w_stb", s_stb, 1);
      chk("w_we", s_we, 1);
      chk("w_grant", grant, 2'b01);
      chk("w_addr", s_addr, 26'h0000010);
      chk("w_dat", s_wdat, 32'hDEADBEEF);
      chk("w_sel", s_sel, 4'hF);
      tick(); chk("w_noack_a", m0_ack, 0);
      tick(); chk("w_noack_b", m0_ack, 0);
      s_ack = 1'b1; #1;
      chk("w_ack0", m0_ack, 1);
      chk("w_ack1", m1_ack, 0);
      tick();
      s_ack = 1'b0; m0_cyc = 0; m0_stb = 0; #1;
      chk("w_ack_once", m0_ack, 0);
      chk("w_hold", grant, 2'b01);
      tick();
      chk("w_idle_grant", grant, 0);
      chk("w_idle_cyc", s_cyc, 0);

      // Tie after reset goes to m0, then direct handoff to m1.
      rst = 1'b1; #1; rst = 1'b0;
      m0_cyc = 1; m0_stb = 1; m0_addr = 26'h20;
      m1_cyc = 1; m1_stb = 1; m1_addr = 26'h30;
      tick();
      chk("tie1_grant", grant, 2'b01);
      chk("tie1_addr", s_addr, 26'h20);
      tick();
      chk("tie1_nopreempt", grant, 2'b01);
      m0_cyc = 0; m0_stb = 0;
      tick();
      chk("handoff_grant", grant, 2'b10);
      chk("handoff_addr", s_addr, 26'h30);
      m1_cyc = 0; m1_stb = 0;
      tick();
      chk("after_m1_idle", grant, 0);
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      tick();
      chk("tie2_grant", grant, 2'b01);

      // m1 incrementing read burst while m0 keeps requesting.
      m0_cyc = 0; m0_stb = 0;
      m1_we = 0; m1_addr = 26'h100; m1_cti = 3'b010;
      tick();
      chk("burst_grant", grant, 2'b10);
      m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 26'h200; #1;
      chk("burst_wait_ack", m1_ack, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         m1_cti = (i == 3) ? 3'b111 : 3'b010;
         m1_addr = 26'h100 + 26'(4 * i);
         s_ack = 1'b1; s_rdat = words[i]; #1;
         chk("burst_dat", m1_rdat, {32'd0, words[i]});
         chk("burst_ack1", m1_ack, 1);
         chk("burst_ack0", m0_ack, 0);
         chk("burst_dat0", m0_rdat, 0);
         chk("burst_cti", s_cti, {61'd0, m1_cti});
         chk("burst_owner", grant, 2'b10);
         tick();
      end
      s_ack = 1'b0; s_rdat = '0; m1_cyc = 0; m1_stb = 0; #1;
      chk("burst_end_hold", grant, 2'b10);
      tick();
      chk("post_burst_grant", grant, 2'b01);
      chk("post_burst_addr", s_addr, 26'h200);

      // Init dropping mid-cycle lets the owner finish but blocks new grants.
      init = 1'b0;
      tick();
      chk("initlow_keep", grant, 2'b01);
      m1_cyc = 1; m1_stb = 1; m0_cyc = 0; m0_stb = 0;
      tick();
      chk("initlow_nogrant_a", grant, 0);
      tick();
      chk("initlow_nogrant_b", grant, 0);
      init = 1'b1;
      tick();
      chk("initup_grant", grant, 2'b10);

      // Asynchronous reset in the middle of a burst.
      m1_cti = 3'b010; s_ack = 1'b1; s_rdat = 32'h55; #1;
      chk("pre_rst_ack", m1_ack, 1);
      #1; rst = 1'b1; #1;
      chk("midrst_cyc", s_cyc, 0);
      chk("midrst_grant", grant, 0);
      chk("midrst_ack", m1_ack, 0);
      chk("midrst_dat", m1_rdat, 0);
      chk("midrst_addr", s_addr, 0);
      rst = 1'b0; s_ack = 1'b0; s_rdat = '0;
      m0_cyc = 1; m0_stb = 1;
      tick();
      chk("postrst_tie", grant, 2'b01);
      chk("err_quiet", m0_err, 0);

`ifdef WB_ARB_TIMEOUT_EN
      // Hung slave: m0 is aborted on its 16th stalled cycle.
      rst = 1'b1; #1; rst = 1'b0;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 0; m1_stb = 0; s_ack = 1'b0;
      tick();
      for (int i = 1; i <= 16; i++) begin
         if (i > 1) tick();
         #1;
         chk("to_err", m0_err, (i == 16) ? 1 : 0);
      end
      m1_cyc = 1; m1_stb = 1;
      tick();
      chk("abort_cyc", s_cyc, 0);
      chk("abort_grant", grant, 0);
      chk("abort_err_pulse", m0_err, 0);
      s_ack = 1'b1; #1;
      chk("abort_late_ack", m0_ack, 0);
      s_ack = 1'b0; m0_cyc = 0; m0_stb = 0;
      tick();
      chk("abort_exit", grant, 0);
      tick();
      chk("abort_m1_grant", grant, 2'b10);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
